// File: rtl/pipeline_reset_sequencer.sv
// pipeline_reset_sequencer: reset synchroniser, staggered per-stage reset release and run/step gating
module pipeline_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_CH      = 5,
    parameter int STAGGER     = 1,
    parameter int CNT_W       = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SoftRst_req,
    input  logic              StepMode,
    input  logic              Step_req,
    output logic [NUM_CH-1:0] ChRst_n,
    output logic              Ready,
    output logic              Run_en,
    output logic [CNT_W-1:0]  CycleCount
);
    localparam logic [1:0] HOLD    = 2'd0;
    localparam logic [1:0] RELEASE = 2'd1;
    localparam logic [1:0] RUN     = 2'd2;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(STAGGER + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   srst_n;
    logic                   step_q;
    logic [1:0]             state;
    logic [HW-1:0]          hold_cnt;
    logic [SW-1:0]          stag_cnt;
    logic [NUM_CH-1:0]      ch_next;

    assign srst_n  = sync[SYNC_STAGES-1];
    assign ch_next = (ChRst_n << 1) | NUM_CH'(1);

    // Board reset asserts immediately, deasserts after SYNC_STAGES edges
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end

    // Step request edge detector runs in every state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) step_q <= 1'b0;
        else        step_q <= Step_req;
    end

    // Sequencer: hold, staggered channel release, then run/step gating with saturating counter
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            stag_cnt   <= '0;
            ChRst_n    <= '0;
            Ready      <= 1'b0;
            Run_en     <= 1'b0;
            CycleCount <= '0;
        end else if (SoftRst_req) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            stag_cnt   <= '0;
            ChRst_n    <= '0;
            Ready      <= 1'b0;
            Run_en     <= 1'b0;
            CycleCount <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (srst_n) begin
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            state    <= (NUM_CH == 1) ? RUN : RELEASE;
                            hold_cnt <= '0;
                            stag_cnt <= '0;
                            ChRst_n  <= NUM_CH'(1);
                            Ready    <= (NUM_CH == 1);
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (stag_cnt == SW'(STAGGER - 1)) begin
                        stag_cnt <= '0;
                        ChRst_n  <= ch_next;
                        if (ch_next[NUM_CH-1]) begin
                            state <= RUN;
                            Ready <= 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt + SW'(1);
                    end
                end
                RUN:     Run_en <= StepMode ? (Step_req & ~step_q) : 1'b1;
                default: state  <= HOLD;
            endcase
            if (Run_en && CycleCount != '1) CycleCount <= CycleCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_reset_sequencer.sv
// tb_pipeline_reset_sequencer: scoreboard bench over default and alternate parameter sets
module tb_pipeline_reset_sequencer;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic SoftRst_req = 1'b0;
    logic StepMode = 1'b0;
    logic Step_req = 1'b0;

    logic [4:0]  ch;     logic rdy, run;         logic [31:0] cnt;
    logic [4:0]  sat_ch; logic sat_rdy, sat_run; logic [3:0]  sat_cnt;
    logic [2:0]  st_ch;  logic st_rdy, st_run;   logic [31:0] st_cnt;
    logic [0:0]  t6_ch;  logic t6_rdy, t6_run;   logic [31:0] t6_cnt;

    pipeline_reset_sequencer dut (
        .Clk(Clk), .Reset(Reset), .SoftRst_req(SoftRst_req), .StepMode(StepMode), .Step_req(Step_req),
        .ChRst_n(ch), .Ready(rdy), .Run_en(run), .CycleCount(cnt));
    pipeline_reset_sequencer #(.CNT_W(4)) dut_sat (
        .Clk(Clk), .Reset(Reset), .SoftRst_req(SoftRst_req), .StepMode(StepMode), .Step_req(Step_req),
        .ChRst_n(sat_ch), .Ready(sat_rdy), .Run_en(sat_run), .CycleCount(sat_cnt));
    pipeline_reset_sequencer #(.NUM_CH(3), .STAGGER(2)) dut_st (
        .Clk(Clk), .Reset(Reset), .SoftRst_req(SoftRst_req), .StepMode(StepMode), .Step_req(Step_req),
        .ChRst_n(st_ch), .Ready(st_rdy), .Run_en(st_run), .CycleCount(st_cnt));
    pipeline_reset_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_CH(1), .STAGGER(3)) dut_t6 (
        .Clk(Clk), .Reset(Reset), .SoftRst_req(SoftRst_req), .StepMode(StepMode), .Step_req(Step_req),
        .ChRst_n(t6_ch), .Ready(t6_rdy), .Run_en(t6_run), .CycleCount(t6_cnt));

    always #5 Clk = ~Clk;

    // Edge number since the last Reset release (edge 1 = first rising edge after release)
    int cyc = 0;
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          edge_n;
        int          sig;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int lim = 99;
    string nm[9] = '{"ChRst_n", "Ready", "Run_en", "CycleCount", "sat_CycleCount",
                     "st_ChRst_n", "st_Ready", "t6_ChRst_n", "t6_Ready"};

    function automatic logic [31:0] act(input int s);
        case (s)
            0: return 32'(ch);
            1: return 32'(rdy);
            2: return 32'(run);
            3: return cnt;
            4: return 32'(sat_cnt);
            5: return 32'(st_ch);
            6: return 32'(st_rdy);
            7: return 32'(t6_ch);
            8: return 32'(t6_rdy);
            default: return 'x;
        endcase
    endfunction

    task automatic ex(input int e, input int s, input int v);
        if (e <= lim) q.push_back('{e, s, 32'(v)});
    endtask

    task automatic zeros();
        for (int s = 0; s < 9; s++) ex(0, s, 0);
    endtask

    task automatic t1_exp();
        ex(5, 0, 0);  ex(6, 0, 1);  ex(7, 0, 3);  ex(8, 0, 7);
        ex(9, 0, 15); ex(9, 1, 0);  ex(10, 0, 31); ex(10, 1, 1);
        ex(10, 2, 0); ex(11, 2, 1); ex(11, 3, 0);
        ex(6, 5, 1);  ex(7, 5, 1);  ex(8, 5, 3);  ex(9, 5, 3);
        ex(9, 6, 0);  ex(10, 5, 7); ex(10, 6, 1);
        ex(3, 7, 0);  ex(3, 8, 0);  ex(4, 7, 1);  ex(4, 8, 1);
    endtask

    task automatic wait_to(input int k);
        int n = 0;
        while (cyc < k && n < 500) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (cyc < k) begin
            $display("FAIL wait_to: reached edge %0d, required edge %0d", cyc, k);
            fails++;
        end
        #1;
    endtask

    // Monitor: on every falling edge pop and compare everything due at the current edge
    initial forever begin
        @(negedge Clk);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].edge_n <= cyc) begin
                tests++;
                if (q[i].edge_n < cyc) begin
                    $display("FAIL %s @edge %0d: never sampled, now at edge %0d", nm[q[i].sig], q[i].edge_n, cyc);
                    fails++;
                end else if (act(q[i].sig) !== q[i].val) begin
                    $display("FAIL %s @edge %0d: got %0h, expected %0h", nm[q[i].sig], cyc, act(q[i].sig), q[i].val);
                    fails++;
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        zeros();
        repeat (3) @(posedge Clk);
        #2;
        t1_exp();
        ex(12, 3, 1); ex(31, 3, 20);
        ex(25, 4, 14); ex(26, 4, 15); ex(31, 4, 15);
        Reset = 1'b1;
        wait_to(31);
        ex(32, 2, 1); ex(32, 3, 21);
        for (int s = 0; s < 6; s++) ex(33, s, 0);
        ex(33, 7, 0); ex(34, 7, 1); ex(34, 8, 1);
        ex(36, 0, 0); ex(37, 0, 1); ex(40, 1, 0); ex(41, 0, 31); ex(41, 1, 1);
        ex(42, 2, 0); ex(42, 3, 0);
        ex(39, 5, 3); ex(41, 5, 7); ex(41, 6, 1);
        wait_to(32);
        SoftRst_req = 1'b1;
        StepMode = 1'b1;
        wait_to(33);
        SoftRst_req = 1'b0;
        ex(44, 2, 1); ex(45, 2, 0); ex(45, 3, 1); ex(48, 2, 0); ex(50, 2, 0);
        ex(51, 2, 1); ex(51, 3, 1); ex(52, 2, 0); ex(52, 3, 2); ex(53, 2, 0);
        ex(53, 3, 2); ex(54, 2, 1); ex(54, 3, 2); ex(55, 2, 1); ex(55, 3, 3);
        wait_to(43);
        Step_req = 1'b1;
        wait_to(48);
        Step_req = 1'b0;
        wait_to(50);
        Step_req = 1'b1;
        wait_to(51);
        Step_req = 1'b0;
        wait_to(53);
        StepMode = 1'b0;
        wait_to(56);
        zeros();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        lim = 7;
        t1_exp();
        Reset = 1'b1;
        wait_to(8);
        lim = 99;
        zeros();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        t1_exp();
        Reset = 1'b1;
        wait_to(12);
        @(negedge Clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
